// File: rtl/insn_buffer_if.sv
// Shared types and the fetch/decode-facing bundle of the instruction buffer.
// The package lives here so the interface and the buffer agree on the entry layout.
package insn_buffer_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] insn_t;

  typedef struct packed {
    addr_t       pc;
    logic [15:0] insn;
    logic        fault;
  } insn_buffer_entry_t;

  localparam int INSN_BUFFER_ENTRY_COUNT = 4;

  typedef logic [$clog2(INSN_BUFFER_ENTRY_COUNT + 1)-1:0] insn_buffer_entry_count_t;

endpackage

interface insn_buffer_if #(
  parameter int ENTRY_COUNT = insn_buffer_pkg::INSN_BUFFER_ENTRY_COUNT
);
  import insn_buffer_pkg::*;

  localparam int CW = $clog2(ENTRY_COUNT + 1);

  logic                         flush;
  insn_buffer_entry_t [1:0]     writeEntry;
  logic [1:0]                   writeCount;
  logic                         writeReady;
  logic                         readValid;
  logic                         readReady;
  addr_t                        readPc;
  insn_t                        readInsn;
  logic                         readFault;
  logic                         readIsCompressed;
  logic [CW-1:0]                count;

  modport slave (
    input  flush, writeEntry, writeCount, readReady,
    output writeReady, readValid, readPc, readInsn, readFault,
           readIsCompressed, count
  );

  modport master (
    output flush, writeEntry, writeCount, readReady,
    input  writeReady, readValid, readPc, readInsn, readFault,
           readIsCompressed, count
  );

endinterface

// File: rtl/insn_buffer.sv
// Halfword instruction buffer between fetch and decode: circular array with head/tail/count.
// Define RAFI_INSN_BUFFER_RVC_EN to enable 16-bit compressed instruction detection.
module insn_buffer
  import insn_buffer_pkg::*;
#(
  parameter int ENTRY_COUNT = INSN_BUFFER_ENTRY_COUNT
) (
  input  logic          clk,
  input  logic          rst,
  insn_buffer_if.slave  bus
);

  localparam int PW = $clog2(ENTRY_COUNT);
  localparam int CW = $clog2(ENTRY_COUNT + 1);

  insn_buffer_entry_t entries_q [ENTRY_COUNT];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  insn_buffer_entry_t headEntry;
  logic [PW-1:0]      secondIdx;
  logic [15:0]        secondInsn;
  logic               secondFault;
  logic               headIsRvc;
  logic [1:0]         headLen;
  logic               readValid;
  logic               writeReady;
  logic [1:0]         wrNum;
  logic [1:0]         rdNum;

  assign headEntry   = entries_q[head_q];
  assign secondIdx   = head_q + PW'(1);
  assign secondInsn  = entries_q[secondIdx].insn;
  assign secondFault = entries_q[secondIdx].fault;

`ifdef RAFI_INSN_BUFFER_RVC_EN
  assign headIsRvc = (headEntry.insn[1:0] != 2'b11);
`else
  assign headIsRvc = 1'b0;
`endif

  // A faulted halfword is handed to decode on its own so the trap is never held up.
  assign headLen    = (headEntry.fault || headIsRvc) ? 2'd1 : 2'd2;
  assign readValid  = (count_q >= CW'(headLen));
  assign writeReady = (count_q <= CW'(ENTRY_COUNT - 2));

  assign wrNum = (writeReady && bus.writeCount != 2'd3) ? bus.writeCount : 2'd0;
  assign rdNum = (readValid && bus.readReady) ? headLen : 2'd0;

  assign bus.readValid        = readValid;
  assign bus.writeReady       = writeReady;
  assign bus.readPc           = headEntry.pc;
  assign bus.readInsn         = (headLen == 2'd1) ? {16'h0000, headEntry.insn}
                                                  : {secondInsn, headEntry.insn};
  assign bus.readFault        = headEntry.fault | ((headLen == 2'd2) & secondFault);
  assign bus.readIsCompressed = headIsRvc;
  assign bus.count            = count_q;

  always_comb begin
    head_d  = head_q + PW'(rdNum);
    tail_d  = tail_q + PW'(wrNum);
    count_d = count_q + CW'(wrNum) - CW'(rdNum);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush) begin
      if (wrNum != 2'd0) begin
        entries_q[tail_q] <= bus.writeEntry[0];
      end
      if (wrNum == 2'd2) begin
        entries_q[tail_q + PW'(1)] <= bus.writeEntry[1];
      end
    end
  end

endmodule

// File: tb/tb_insn_buffer.sv
// Directed self-checking bench for insn_buffer with hand-computed expectations.
module tb_insn_buffer;
  import insn_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  insn_buffer_if #(.ENTRY_COUNT(4)) bufIf();

  insn_buffer #(.ENTRY_COUNT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bufIf.slave)
  );

  function automatic insn_buffer_entry_t mkEntry(input logic [31:0] pc,
                                                 input logic [15:0] insn,
                                                 input logic fault);
    insn_buffer_entry_t e;
    e.pc    = pc;
    e.insn  = insn;
    e.fault = fault;
    return e;
  endfunction

  task automatic applyStimulus(input logic fl, input logic [1:0] wc,
                               input insn_buffer_entry_t e0,
                               input insn_buffer_entry_t e1,
                               input logic rr);
    bufIf.flush         = fl;
    bufIf.writeCount    = wc;
    bufIf.writeEntry[0] = e0;
    bufIf.writeEntry[1] = e1;
    bufIf.readReady     = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic valid,
                            input logic wready, input int cnt);
    checkOutput({tag, ".readValid"}, 32'(bufIf.readValid), 32'(valid));
    checkOutput({tag, ".writeReady"}, 32'(bufIf.writeReady), 32'(wready));
    checkOutput({tag, ".count"}, 32'(bufIf.count), 32'(cnt));
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc,
                           input logic [31:0] insn, input logic fault);
    checkOutput({tag, ".readPc"}, bufIf.readPc, pc);
    checkOutput({tag, ".readInsn"}, bufIf.readInsn, insn);
    checkOutput({tag, ".readFault"}, 32'(bufIf.readFault), 32'(fault));
  endtask

  insn_buffer_entry_t none;

  initial begin
    none = mkEntry(32'h0, 16'h0, 1'b0);

    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, none, none, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    checkState("reset", 1'b0, 1'b1, 0);

    // Basic 32-bit instruction
    applyStimulus(1'b0, 2'd2, mkEntry(32'h80000000, 16'h0093, 1'b0),
                  mkEntry(32'h80000002, 16'h0010, 1'b0), 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, none, none, 1'b1);
    checkState("basic", 1'b1, 1'b1, 2);
    checkHead("basic", 32'h80000000, 32'h00100093, 1'b0);
    checkOutput("basic.readIsCompressed", 32'(bufIf.readIsCompressed), 32'd0);
    tick();
    checkState("basicDrained", 1'b0, 1'b1, 0);

    // Fill to full, third write dropped
    applyStimulus(1'b0, 2'd2, mkEntry(32'h80000004, 16'h0113, 1'b0),
                  mkEntry(32'h80000006, 16'h0020, 1'b0), 1'b0);
    tick();
    checkState("fill2", 1'b1, 1'b1, 2);
    applyStimulus(1'b0, 2'd2, mkEntry(32'h80000008, 16'h0193, 1'b0),
                  mkEntry(32'h8000000a, 16'h0030, 1'b0), 1'b0);
    tick();
    checkState("fill4", 1'b1, 1'b0, 4);
    applyStimulus(1'b0, 2'd2, mkEntry(32'h8000000c, 16'h0293, 1'b0),
                  mkEntry(32'h8000000e, 16'h0050, 1'b0), 1'b0);
    tick();
    checkState("fullDrop", 1'b1, 1'b0, 4);
    applyStimulus(1'b0, 2'd0, none, none, 1'b1);
    checkHead("drain0", 32'h80000004, 32'h00200113, 1'b0);
    tick();
    checkState("drain1", 1'b1, 1'b1, 2);
    checkHead("drain1", 32'h80000008, 32'h00300193, 1'b0);

    // Simultaneous read and write at count 2
    applyStimulus(1'b0, 2'd2, mkEntry(32'h80000010, 16'h0213, 1'b0),
                  mkEntry(32'h80000012, 16'h0040, 1'b0), 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, none, none, 1'b1);
    checkState("rdwr", 1'b1, 1'b1, 2);
    checkHead("rdwr", 32'h80000010, 32'h00400213, 1'b0);
    tick();
    checkState("rdwrDrained", 1'b0, 1'b1, 0);

    // Split 32-bit instruction, one halfword per cycle
    applyStimulus(1'b0, 2'd1, mkEntry(32'h80000020, 16'h0093, 1'b0), none, 1'b1);
    tick();
    checkState("half1", 1'b0, 1'b1, 1);
    applyStimulus(1'b0, 2'd1, mkEntry(32'h80000022, 16'h0010, 1'b0), none, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, none, none, 1'b1);
    checkState("half2", 1'b1, 1'b1, 2);
    checkHead("half2", 32'h80000020, 32'h00100093, 1'b0);
    tick();
    checkState("halfDrained", 1'b0, 1'b1, 0);

    // Flush with one halfword held, overriding a same-cycle write
    applyStimulus(1'b0, 2'd1, mkEntry(32'h80000024, 16'h0093, 1'b0), none, 1'b0);
    tick();
    checkState("preFlush", 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 2'd2, mkEntry(32'h80000026, 16'h0010, 1'b0),
                  mkEntry(32'h80000028, 16'h0113, 1'b0), 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, none, none, 1'b0);
    checkState("flush", 1'b0, 1'b1, 0);
    tick();
    checkState("postFlush", 1'b0, 1'b1, 0);

    // Faulted head halfword emitted alone
    applyStimulus(1'b0, 2'd2, mkEntry(32'h80000030, 16'h0093, 1'b1),
                  mkEntry(32'h80000032, 16'h0010, 1'b0), 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, none, none, 1'b1);
    checkState("fault", 1'b1, 1'b1, 2);
    checkHead("fault", 32'h80000030, 32'h00000093, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, none, none, 1'b0);
`ifdef RAFI_INSN_BUFFER_RVC_EN
    checkState("afterFault", 1'b1, 1'b1, 1);
    checkHead("afterFault", 32'h80000032, 32'h00000010, 1'b0);
`else
    checkState("afterFault", 1'b0, 1'b1, 1);
`endif
    applyStimulus(1'b1, 2'd0, none, none, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, none, none, 1'b0);
    checkState("faultFlush", 1'b0, 1'b1, 0);

    // Compressed pair (or one 32-bit instruction without RVC)
    applyStimulus(1'b0, 2'd2, mkEntry(32'h80000040, 16'h4501, 1'b0),
                  mkEntry(32'h80000042, 16'h4585, 1'b0), 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, none, none, 1'b1);
`ifdef RAFI_INSN_BUFFER_RVC_EN
    checkHead("rvc0", 32'h80000040, 32'h00004501, 1'b0);
    checkOutput("rvc0.readIsCompressed", 32'(bufIf.readIsCompressed), 32'd1);
    tick();
    checkState("rvc1", 1'b1, 1'b1, 1);
    checkHead("rvc1", 32'h80000042, 32'h00004585, 1'b0);
    checkOutput("rvc1.readIsCompressed", 32'(bufIf.readIsCompressed), 32'd1);
    tick();
`else
    checkHead("norvc", 32'h80000040, 32'h45854501, 1'b0);
    checkOutput("norvc.readIsCompressed", 32'(bufIf.readIsCompressed), 32'd0);
    tick();
`endif
    checkState("rvcDrained", 1'b0, 1'b1, 0);

    // Streaming across several pointer wraps
    for (int i = 0; i < 8; i++) begin
      logic [15:0] lo;
      logic [15:0] hi;
      logic [31:0] pc;
      lo = 16'h0013 | 16'(i << 8);
      hi = 16'(i + 1);
      pc = 32'h80000100 + 32'(i * 4);
      applyStimulus(1'b0, 2'd2, mkEntry(pc, lo, 1'b0), mkEntry(pc + 32'd2, hi, 1'b0), 1'b1);
      tick();
      checkOutput("stream.count", 32'(bufIf.count), 32'd2);
      checkHead("stream", pc, {hi, lo}, 1'b0);
    end
    applyStimulus(1'b0, 2'd0, none, none, 1'b1);
    tick();
    checkState("streamDrained", 1'b0, 1'b1, 0);

    // Reset with half an instruction held, overriding write and read
    applyStimulus(1'b0, 2'd1, mkEntry(32'h80000200, 16'h0093, 1'b0), none, 1'b0);
    tick();
    checkState("preReset", 1'b0, 1'b1, 1);
    rst = 1'b1;
    applyStimulus(1'b1, 2'd2, mkEntry(32'h80000202, 16'h0010, 1'b0),
                  mkEntry(32'h80000204, 16'h0113, 1'b0), 1'b1);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 2'd0, none, none, 1'b0);
    checkState("midReset", 1'b0, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/insn_buffer.md
INSN_BUFFER -- requirements
Module: InsnBuffer

Interface
REQ-001 SHALL have parameter ENTRY_COUNT, default INSN_BUFFER_ENTRY_COUNT (4), buffer depth in 16-bit halfword entries; power of two, >=4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  discard all buffered entries (redirect/trap).
REQ-005 SHALL have port writeEntry  input  2 x InsnBufferEntry  halfwords from fetch; slot 0 is older.
REQ-006 SHALL have port writeCount  input  2  number of valid slots in writeEntry (0..2; 3 illegal).
REQ-007 SHALL have port writeReady  output  1  at least 2 free entries.
REQ-008 SHALL have port readValid  output  1  a complete instruction is at the head.
REQ-009 SHALL have port readReady  input  1  decode accepts the head instruction.
REQ-010 SHALL have port readPc  output  32 (addr_t)  pc of first halfword of head instruction.
REQ-011 SHALL have port readInsn  output  32 (insn_t)  head instruction bits.
REQ-012 SHALL have port readFault  output  1  fetch fault on any consumed halfword.
REQ-013 SHALL have port readIsCompressed  output  1  head instruction is 16-bit.
REQ-014 SHALL have port count  output  insn_buffer_entry_count_t  occupied entries.

Function
REQ-015 SHALL store entries in a circular array with head/tail pointers wrapping modulo ENTRY_COUNT and a separate occupancy counter (0..ENTRY_COUNT).
REQ-016 writeReady SHALL equal (ENTRY_COUNT - count >= 2), derived from registered state only, never from readReady or flush.
REQ-017 Write SHALL occur when writeReady=1 and writeCount>0: slots 0..writeCount-1 appended in order; writeCount>0 with writeReady=0 SHALL be ignored, fetch holds.
REQ-018 Written entries SHALL become visible to the read side one cycle after the write edge (no write-to-read bypass).
REQ-019 Head length: 1 halfword if RVC enabled and head insn[1:0]!=2'b11 or head fault=1; otherwise 2 halfwords.
REQ-020 readValid SHALL be 1 iff count >= head length.
REQ-021 32-bit: readInsn = {second.insn, head.insn}; 16-bit: readInsn = {16'h0, head.insn}; readPc = head.pc.
REQ-022 readFault SHALL be OR of fault bits of consumed halfwords; a faulted head halfword SHALL be emitted alone without waiting for a second halfword.
REQ-023 Read SHALL occur when readValid && readReady: head advances and count decrements by head length.
REQ-024 Simultaneous read and write SHALL update count by +writeCount - headLength in one cycle; write acceptance is based on pre-read count.
REQ-025 flush SHALL, on the next edge, set head=tail=0 and count=0, overriding any same-cycle write or read; readValid=0 the following cycle.
REQ-026 readValid=0 SHALL make readPc/readInsn/readFault/readIsCompressed don't-care; readValid SHALL NOT depend combinationally on readReady.

Reset
REQ-027 On rst=1 at an edge: head=0, tail=0, count=0; thus readValid=0, writeReady=1, count=0; rst overrides flush, write and read, including mid-instruction (half of a 32-bit insn held).
REQ-028 Array contents SHALL NOT require reset.

Configuration
REQ-029 Macro RAFI_INSN_BUFFER_RVC_EN: defined -> 16-bit compressed detection per REQ-019, readIsCompressed valid; undefined -> every non-faulted instruction consumes 2 halfwords, readIsCompressed tied 0, compressed logic absent.

Verification
REQ-030 Reset, then writeCount=2 {pc 0x80000000 insn 0x0093, pc 0x80000002 insn 0x0010}, readReady=1 -> next cycle readValid=1, readInsn=0x00100093, readPc=0x80000000, count 2->0.
REQ-031 RVC_EN: write {0x4501, 0x4585} at 0x80000000 -> two reads: readInsn=0x00004501 pc 0x80000000, then 0x00004585 pc 0x80000002, readIsCompressed=1 both.
REQ-032 readReady=0, write 2 per cycle -> count 2 then 4, writeReady=0 at count 4; a third writeCount=2 is dropped, count stays 4.
REQ-033 Single halfword 0x0093 (32-bit low half) written -> readValid=0 until upper half written next cycle, then readValid=1; flush with count=1 -> count=0, readValid=0.
REQ-034 Head halfword fault=1 -> readValid=1, readFault=1, consumes 1 entry, regardless of RVC_EN.
REQ-035 Continuous streaming past 8 writes -> pointers wrap, pc/insn ordering preserved, no loss or duplication.
